// File: rtl/cc_pkg.sv
// Cache controller shared definitions: AXI read-burst encodings, line geometry,
// and the miss request FSM state type.
package cc_pkg;

    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [3:0] CC_ARLEN       = 4'd7;
    localparam logic [2:0] CC_ARSIZE      = 3'd3;

    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 9;
    localparam int TAG_W    = 17;

    typedef enum logic {
        MRQ_IDLE = 1'b0,
        MRQ_REQ  = 1'b1
    } miss_req_state_t;

    // Critical-word-first: the wrap burst starts at the 8-byte beat holding the miss.
    function automatic logic [31:0] beat_align(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/cc_outstanding_counter.sv
// Saturating up/down counter of in-flight line fills; simultaneous inc and dec
// cancel, and the count never leaves the range 0..MAX.
module cc_outstanding_counter #(
    parameter  int MAX   = 4,
    localparam int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_full
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (r_cnt == CNT_W'(MAX));
    assign w_empty = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !w_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc && !w_empty) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_full = w_full;

endmodule

// File: rtl/cc_miss_req_unit.sv
// Miss request issuer: accepts one miss, pushes its address to the miss FIFO and
// issues the matching 8-beat wrap read burst, bounded by the in-flight fill count.
module cc_miss_req_unit
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_valid_i,
    input  logic [31:0] miss_addr_i,
    output logic        miss_ready_o,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    miss_req_state_t  r_state;
    miss_req_state_t  w_state_nxt;
    logic [31:0]      r_addr;
    logic             r_wren;
    logic             w_accept;
    logic             w_fill_done;
    logic             w_cnt_full;
    logic [CNT_W-1:0] w_outst_cnt;

    assign w_accept    = miss_valid_i & miss_ready_o;
    assign w_fill_done = mem_rvalid_i & mem_rready_i & mem_rlast_i;

    cc_outstanding_counter #(
        .MAX (MAX_OUTSTANDING)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_accept),
        .i_dec  (w_fill_done),
        .o_cnt  (w_outst_cnt),
        .o_full (w_cnt_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MRQ_IDLE;
            r_addr  <= '0;
            r_wren  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wren  <= w_accept;
            if (w_accept) begin
                r_addr <= miss_addr_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MRQ_IDLE: if (w_accept)      w_state_nxt = MRQ_REQ;
            MRQ_REQ:  if (mem_arready_i) w_state_nxt = MRQ_IDLE;
            default:                     w_state_nxt = MRQ_IDLE;
        endcase
    end

    // The push is one-shot on the first REQ cycle; full was already checked at accept.
    assign miss_ready_o           = (r_state == MRQ_IDLE) & ~miss_addr_fifo_full_i & ~w_cnt_full;
    assign miss_addr_fifo_wren_o  = r_wren;
    assign miss_addr_fifo_wdata_o = r_addr;

    assign mem_arvalid_o = (r_state == MRQ_REQ);
    assign mem_araddr_o  = beat_align(r_addr);
    assign mem_arlen_o   = CC_ARLEN;
    assign mem_arsize_o  = CC_ARSIZE;
    assign mem_arburst_o = AXI_BURST_WRAP;

endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Directed bench for cc_miss_req_unit with MAX_OUTSTANDING=2.
module tb_cc_miss_req_unit;

    logic        clk;
    logic        rst_n;
    logic        miss_valid_i;
    logic [31:0] miss_addr_i;
    logic        miss_ready_o;
    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_rvalid_i;
    logic        mem_rready_i;
    logic        mem_rlast_i;

    int total = 0;
    int bad   = 0;

    cc_miss_req_unit #(
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_valid_i           (miss_valid_i),
        .miss_addr_i            (miss_addr_i),
        .miss_ready_o           (miss_ready_o),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_arready_i          (mem_arready_i),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rready_i           (mem_rready_i),
        .mem_rlast_i            (mem_rlast_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed at posedge+2, outputs checked at posedge+3.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rlast_pulse();
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b1;
        mem_rlast_i  = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i  = 1'b0;
    endtask

    // Accept a miss at the current cycle with arready high, ending back in IDLE.
    task automatic quick_miss(input logic [31:0] addr);
        miss_valid_i  = 1'b1;
        miss_addr_i   = addr;
        mem_arready_i = 1'b1;
        tick();
        miss_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        miss_valid_i = 1'b0;
        miss_addr_i = '0;
        miss_addr_fifo_full_i = 1'b0;
        mem_arready_i = 1'b1;
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i = 1'b0;

        #3;
        chk("rst_arvalid", mem_arvalid_o, 0);
        chk("rst_wren",    miss_addr_fifo_wren_o, 0);
        chk("rst_araddr",  mem_araddr_o, 0);
        chk("rst_ready",   miss_ready_o, 1);
        chk("rst_cnt",     32'(dut.u_cnt.o_cnt), 0);
        #4 rst_n = 1'b1;
        tick();

        // Single miss with arready tied high.
        miss_valid_i = 1'b1;
        miss_addr_i  = 32'h1234_5678;
        #1 chk("t1_ready_N", miss_ready_o, 1);
        tick();
        miss_valid_i = 1'b0;
        #1;
        chk("t1_wren",    miss_addr_fifo_wren_o, 1);
        chk("t1_wdata",   miss_addr_fifo_wdata_o, 32'h1234_5678);
        chk("t1_arvalid", mem_arvalid_o, 1);
        chk("t1_araddr",  mem_araddr_o, 32'h1234_5678);
        chk("t1_arlen",   mem_arlen_o, 7);
        chk("t1_arsize",  mem_arsize_o, 3);
        chk("t1_arburst", mem_arburst_o, 2);
        chk("t1_ready_N1", miss_ready_o, 0);
        tick();
        #1;
        chk("t1_arvalid_N2", mem_arvalid_o, 0);
        chk("t1_wren_N2",    miss_addr_fifo_wren_o, 0);
        chk("t1_cnt",        32'(dut.u_cnt.o_cnt), 1);
        rlast_pulse();
        #1 chk("t1_cnt_done", 32'(dut.u_cnt.o_cnt), 0);

        // arready low for 5 cycles after the accept.
        miss_valid_i  = 1'b1;
        miss_addr_i   = 32'hDEAD_BEE4;
        mem_arready_i = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            mem_arready_i = (i == 5);
            #1;
            chk("t2_arvalid", mem_arvalid_o, 1);
            chk("t2_araddr",  mem_araddr_o, 32'hDEAD_BEE0);
            chk("t2_wren",    miss_addr_fifo_wren_o, (i == 0) ? 32'd1 : 32'd0);
            chk("t2_ready",   miss_ready_o, 0);
            tick();
        end
        miss_valid_i = 1'b0;
        #1 chk("t2_arvalid_end", mem_arvalid_o, 0);
        rlast_pulse();

        // rlast with an empty count must be ignored.
        rlast_pulse();
        #1 chk("t3_cnt_floor", 32'(dut.u_cnt.o_cnt), 0);

        // Fill the two outstanding slots.
        quick_miss(32'h0000_1000);
        quick_miss(32'h0000_2000);
        miss_valid_i = 1'b1;
        miss_addr_i  = 32'h0000_3000;
        #1;
        chk("t3_cnt_max",   32'(dut.u_cnt.o_cnt), 2);
        chk("t3_ready_max", miss_ready_o, 0);
        tick();
        #1;
        chk("t3_ready_max2", miss_ready_o, 0);
        chk("t3_no_arvalid", mem_arvalid_o, 0);
        chk("t3_no_wren",    miss_addr_fifo_wren_o, 0);
        miss_valid_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b1;
        mem_rlast_i  = 1'b1;
        #1 chk("t3_ready_same", miss_ready_o, 0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i  = 1'b0;
        #1;
        chk("t3_ready_after", miss_ready_o, 1);
        chk("t3_cnt_one",     32'(dut.u_cnt.o_cnt), 1);
        // Accept and completion in one cycle leave the count unchanged.
        miss_valid_i = 1'b1;
        miss_addr_i  = 32'h0000_4000;
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b1;
        mem_rlast_i  = 1'b1;
        tick();
        miss_valid_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i  = 1'b0;
        #1;
        chk("t3_cnt_cancel", 32'(dut.u_cnt.o_cnt), 1);
        chk("t3_wren_cancel", miss_addr_fifo_wren_o, 1);
        tick();
        quick_miss(32'h0000_5000);
        #1;
        chk("t3_cnt_two",  32'(dut.u_cnt.o_cnt), 2);
        chk("t3_ready_two", miss_ready_o, 0);
        rlast_pulse();
        rlast_pulse();
        #1 chk("t3_cnt_drain", 32'(dut.u_cnt.o_cnt), 0);

        // FIFO full blocks the accept until it clears.
        miss_addr_fifo_full_i = 1'b1;
        miss_valid_i = 1'b1;
        miss_addr_i  = 32'hCAFE_0010;
        #1 chk("t4_ready_full", miss_ready_o, 0);
        tick();
        #1;
        chk("t4_no_wren",    miss_addr_fifo_wren_o, 0);
        chk("t4_no_arvalid", mem_arvalid_o, 0);
        miss_addr_fifo_full_i = 1'b0;
        #1 chk("t4_ready_clear", miss_ready_o, 1);
        tick();
        miss_valid_i = 1'b0;
        #1;
        chk("t4_wren",  miss_addr_fifo_wren_o, 1);
        chk("t4_wdata", miss_addr_fifo_wdata_o, 32'hCAFE_0010);
        tick();
        rlast_pulse();

        // Asynchronous reset while AR is outstanding.
        mem_arready_i = 1'b0;
        miss_valid_i  = 1'b1;
        miss_addr_i   = 32'h8000_0040;
        tick();
        miss_valid_i = 1'b0;
        #1 chk("t5_arvalid_pre", mem_arvalid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_arvalid_async", mem_arvalid_o, 0);
        chk("t5_wren_async",    miss_addr_fifo_wren_o, 0);
        tick();
        rst_n = 1'b1;
        mem_arready_i = 1'b1;
        tick();
        #1;
        chk("t5_cnt",   32'(dut.u_cnt.o_cnt), 0);
        chk("t5_ready", miss_ready_o, 1);

        // Unaligned address: AR aligns to the beat, FIFO keeps the raw address.
        miss_valid_i = 1'b1;
        miss_addr_i  = 32'h0000_0FFF;
        tick();
        miss_valid_i = 1'b0;
        #1;
        chk("t6_araddr", mem_araddr_o, 32'h0000_0FF8);
        chk("t6_wdata",  miss_addr_fifo_wdata_o, 32'h0000_0FFF);
        tick();
        #1 chk("t6_arvalid_end", mem_arvalid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
